rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Write-back arbiter and read-bypass unit for the 32x32-bit, 2-read/1-write register file.
- Shares the single write port (write enable, 5-bit write address, 32-bit write data) among NUM_REQ producers (ALU, load unit, multiplier, ...) using round-robin.
- Registers the granted write for one cycle, then presents it to the register file.
- Forwards that in-flight write to both read ports, so readers never see stale data.

Parameters:
- NUM_REQ, 3, number of write-back requesters (2..8)
- PTR_W, 2, width of round-robin pointer; must equal ceil(log2(NUM_REQ))

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- req_valid  input  NUM_REQ  per-requester write request
- req_addr  input  NUM_REQ*5  flat; requester i at bits [5i+4:5i]
- req_data  input  NUM_REQ*32  flat; requester i at bits [32i+31:32i]
- req_ready  output  NUM_REQ  one-hot grant; transfer when valid&ready
- wb_stall  input  1  blocks all grants this cycle
- rf_we  output  1  to register file write enable
- rf_waddr  output  5  to register file write address
- rf_wdata  output  32  to register file write data
- rd_addr1  input  5  read port 1 address (also drives register file A1)
- rd_addr2  input  5  read port 2 address (also drives register file A2)
- rf_q1  input  32  register file read data 1
- rf_q2  input  32  register file read data 2
- fwd_q1  output  32  bypassed read data 1
- fwd_q2  output  32  bypassed read data 2
- grant_id  output  PTR_W  index of current grant (valid only when |req_ready)

Behaviour:
- Reset (sync, active-high):
  - rf_we=0, rf_waddr=0, rf_wdata=0, rr_ptr=0.
  - req_ready forced to 0 while reset=1.
- Arbitration (combinational, same cycle):
  - Search requesters starting at rr_ptr and wrapping modulo NUM_REQ; the first with req_valid=1 wins.
  - req_ready is set only for the winner; at most one bit is high.
  - No winner, or wb_stall=1 → req_ready=0.
  - grant_id = winner index; holds its last value when there is no grant.
- Handshake:
  - A requester holds req_valid, req_addr and req_data stable until it sees req_ready=1.
  - Transfer occurs on the clk edge where valid&ready.
  - Deasserting valid before a grant is allowed (the request is withdrawn, nothing is written).
- Output stage (registered, latency 1):
  - On a transfer edge: rf_we←1, rf_waddr←req_addr[winner], rf_wdata←req_data[winner].
  - Otherwise rf_we←0; rf_waddr and rf_wdata hold their previous values.
  - The register file captures on the following edge, so total latency from grant to architectural update is 2 edges.
- Round-robin pointer:
  - After a transfer by i, rr_ptr←(i+1) mod NUM_REQ.
  - Unchanged when there is no transfer or wb_stall=1.
  - Fairness guarantee: a requester holding valid with wb_stall=0 is granted within NUM_REQ cycles.
- Bypass (combinational):
  - fwd_qN = rf_wdata if rf_we=1 and rf_waddr==rd_addrN; else rf_qN.
  - Applies to address 0 as well; the register file has no hardwired zero.
  - Both ports may forward simultaneously.
- Same address in consecutive cycles: each write is committed in order. The bypass always reflects the newest in-flight write, because only one stage exists.
- wb_stall asserted while rf_we=1: the pending write still completes (rf_we drops next cycle); only new grants are blocked.
- Reset mid-operation: the in-flight write is dropped (rf_we=0 after the edge), rr_ptr returns to 0, and requesters must re-present.
- No X is ever driven: when no requester is selected the output mux defaults to requester 0's fields, but rf_we=0.

Test Plan:
- Reset: drive req_valid=3'b111 with reset=1 for 2 cycles → req_ready=0, rf_we=0, rf_waddr=0, rf_wdata=0; after release, first grant goes to requester 0.
- Round-robin: hold req_valid=3'b111 with addrs 1/2/3 and data 0xA/0xB/0xC → grants 0,1,2,0,…; rf_we=1 every cycle from cycle 1; rf_waddr sequence 1,2,3,1.
- Single requester plus wrap: only requester 2 valid, addr 31, data 0xDEADBEEF → req_ready=3'b100 the same cycle; next cycle rf_we=1, rf_waddr=31, rf_wdata=0xDEADBEEF; rr_ptr wraps to 0.
- Stall: wb_stall=1 for 3 cycles with req_valid=3'b011 → req_ready=0, rf_we=0 after the pending write drains, rr_ptr unchanged; on release, grant goes to the requester at the prior rr_ptr.
- Bypass: write addr 5 data 0x12345678 in flight (rf_we=1) with rd_addr1=5, rd_addr2=6, rf_q1=0 → fwd_q1=0x12345678, fwd_q2=rf_q2. Repeat with rd_addr1=rd_addr2=5 → both forward.
- Reset mid-write: assert reset on the cycle rf_we=1 (addr 7) → next cycle rf_we=0 and rr_ptr=0; fwd_q1 for rd_addr1=7 returns rf_q1.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file write port, with a one-stage
// registered write and read bypass of that in-flight write to both read ports.
module rf_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*5-1:0]    req_addr,
    input  logic [NUM_REQ*32-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic                    wb_stall,
    output logic                    rf_we,
    output logic [4:0]              rf_waddr,
    output logic [31:0]             rf_wdata,
    input  logic [4:0]              rd_addr1,
    input  logic [4:0]              rd_addr2,
    input  logic [31:0]             rf_q1,
    input  logic [31:0]             rf_q2,
    output logic [31:0]             fwd_q1,
    output logic [31:0]             fwd_q2,
    output logic [PTR_W-1:0]        grant_id
);

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] gid_q;
    logic [PTR_W-1:0] win_idx, sel_idx, cand;
    logic [PTR_W:0]   sum, nxt;
    logic             win_found, grant;
    logic             rf_we_q;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [31:0]      rf_wdata_q, rf_wdata_d;

    // Scan offsets from the far end down so the requester closest to rr_ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        sum       = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ))
                sum = sum - (PTR_W+1)'(NUM_REQ);
            cand = sum[PTR_W-1:0];
            if (req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign grant     = win_found & ~wb_stall & ~reset;
    assign req_ready = grant ? (NUM_REQ'(1) << win_idx) : '0;
    assign grant_id  = grant ? win_idx : gid_q;

    // Idle selection falls back to requester 0 so the mux never carries X.
    assign sel_idx    = grant ? win_idx : '0;
    assign rf_waddr_d = req_addr[int'(sel_idx)*5 +: 5];
    assign rf_wdata_d = req_data[int'(sel_idx)*32 +: 32];

    always_comb begin
        nxt      = {1'b0, win_idx} + (PTR_W+1)'(1);
        rr_ptr_d = rr_ptr_q;
        if (grant)
            rr_ptr_d = (nxt == (PTR_W+1)'(NUM_REQ)) ? '0 : nxt[PTR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            rr_ptr_q   <= '0;
            gid_q      <= '0;
        end else begin
            rf_we_q  <= grant;
            rr_ptr_q <= rr_ptr_d;
            if (grant) begin
                rf_waddr_q <= rf_waddr_d;
                rf_wdata_q <= rf_wdata_d;
                gid_q      <= win_idx;
            end
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    assign fwd_q1 = (rf_we_q && rf_waddr_q == rd_addr1) ? rf_wdata_q : rf_q1;
    assign fwd_q2 = (rf_we_q && rf_waddr_q == rd_addr2) ? rf_wdata_q : rf_q2;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a cycle model of the arbitration, write
// stage and bypass is checked every cycle, plus literal spot values.
module tb_rf_wb_arbiter;
    localparam int N = 3;

    logic           clk = 1'b0;
    logic           reset, wb_stall;
    logic [N-1:0]   req_valid;
    logic [4:0]     a [N];
    logic [31:0]    d [N];
    logic [N*5-1:0] req_addr;
    logic [N*32-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           rf_we;
    logic [4:0]     rf_waddr, rd_addr1, rd_addr2;
    logic [31:0]    rf_wdata, rf_q1, rf_q2, fwd_q1, fwd_q2;
    logic [1:0]     grant_id;

    int checks = 0;
    int errors = 0;

    // Model state: what the registered write stage and pointer must hold.
    int  m_ptr;
    bit  m_known;
    bit  m_we;
    int  m_waddr, m_wdata;

    assign req_addr = {a[2], a[1], a[0]};
    assign req_data = {d[2], d[1], d[0]};

    always #5 clk = ~clk;

    rf_wb_arbiter #(.NUM_REQ(N), .PTR_W(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .wb_stall(wb_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rf_q1(rf_q1), .rf_q2(rf_q2),
        .fwd_q1(fwd_q1), .fwd_q2(fwd_q2), .grant_id(grant_id)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Winner index under the current inputs, or -1 when nothing is granted.
    function automatic int model_winner();
        if (reset || wb_stall) return -1;
        for (int k = 0; k < N; k++)
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic settle();
        int w;
        logic [31:0] e1, e2;
        #1;
        w = model_winner();
        chk("req_ready", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
        if (w >= 0) chk("grant_id", 32'(grant_id), 32'(w));
        if (m_known) begin
            chk("rf_we", 32'(rf_we), 32'(m_we));
            chk("rf_waddr", 32'(rf_waddr), 32'(m_waddr));
            chk("rf_wdata", rf_wdata, 32'(m_wdata));
            e1 = (m_we && m_waddr == int'(rd_addr1)) ? 32'(m_wdata) : rf_q1;
            e2 = (m_we && m_waddr == int'(rd_addr2)) ? 32'(m_wdata) : rf_q2;
            chk("fwd_q1", fwd_q1, e1);
            chk("fwd_q2", fwd_q2, e2);
        end
    endtask

    task automatic adv();
        int w;
        w = model_winner();
        @(posedge clk);
        if (reset) begin
            m_known = 1'b1;
            m_we = 1'b0; m_waddr = 0; m_wdata = 0; m_ptr = 0;
        end else if (w >= 0) begin
            m_we = 1'b1; m_waddr = int'(a[w]); m_wdata = int'(d[w]);
            m_ptr = (w + 1) % N;
        end else begin
            m_we = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        m_ptr = 0; m_known = 1'b0; m_we = 1'b0; m_waddr = 0; m_wdata = 0;
        reset = 1'b1; wb_stall = 1'b0; req_valid = '0;
        rd_addr1 = '0; rd_addr2 = '0; rf_q1 = '0; rf_q2 = '0;
        for (int i = 0; i < N; i++) begin a[i] = '0; d[i] = '0; end
        @(negedge clk);

        // Reset with all requesters asking
        req_valid = 3'b111;
        a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3;
        d[0] = 32'hA; d[1] = 32'hB; d[2] = 32'hC;
        settle(); chk("rst_ready0", 32'(req_ready), 0); adv();
        settle(); chk("rst_ready1", 32'(req_ready), 0);
        chk("rst_we", 32'(rf_we), 0); chk("rst_waddr", 32'(rf_waddr), 0);
        chk("rst_wdata", rf_wdata, 0); adv();

        // Round robin 0,1,2,0
        reset = 1'b0;
        settle(); chk("rr_g0", 32'(req_ready), 32'b001); adv();
        settle(); chk("rr_g1", 32'(req_ready), 32'b010); chk("rr_wa1", 32'(rf_waddr), 1); adv();
        settle(); chk("rr_g2", 32'(req_ready), 32'b100); chk("rr_wa2", 32'(rf_waddr), 2); adv();
        settle(); chk("rr_g3", 32'(req_ready), 32'b001); chk("rr_wa3", 32'(rf_waddr), 3); adv();

        // Only requester 2, addr 31
        req_valid = 3'b100; a[2] = 5'd31; d[2] = 32'hDEADBEEF;
        settle(); chk("single_ready", 32'(req_ready), 32'b100); chk("rr_wa4", 32'(rf_waddr), 1); adv();
        req_valid = 3'b000;
        settle(); chk("single_we", 32'(rf_we), 1); chk("single_wa", 32'(rf_waddr), 31);
        chk("single_wd", rf_wdata, 32'hDEADBEEF); adv();

        // Stall after one write, pointer must hold
        req_valid = 3'b011; a[0] = 5'd9; a[1] = 5'd10; d[0] = 32'h90; d[1] = 32'h100;
        settle(); chk("pre_stall_g", 32'(req_ready), 32'b001); adv();
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle(); chk("stall_ready", 32'(req_ready), 0);
            chk("stall_we", 32'(rf_we), (i == 0) ? 32'd1 : 32'd0); adv();
        end
        wb_stall = 1'b0;
        settle(); chk("post_stall_g", 32'(req_ready), 32'b010); adv();

        // Bypass, one port then both, then address 0
        req_valid = 3'b001; a[0] = 5'd5; d[0] = 32'h12345678;
        settle(); chk("byp_g", 32'(req_ready), 32'b001); adv();
        req_valid = 3'b000; rd_addr1 = 5'd5; rd_addr2 = 5'd6; rf_q1 = 32'h0; rf_q2 = 32'h55;
        settle(); chk("byp_q1", fwd_q1, 32'h12345678); chk("byp_q2", fwd_q2, 32'h55); adv();
        req_valid = 3'b001; d[0] = 32'hCAFEF00D;
        settle(); adv();
        req_valid = 3'b000; rd_addr2 = 5'd5;
        settle(); chk("byp2_q1", fwd_q1, 32'hCAFEF00D); chk("byp2_q2", fwd_q2, 32'hCAFEF00D); adv();
        req_valid = 3'b010; a[1] = 5'd0; d[1] = 32'h0BADF00D;
        settle(); chk("z_g", 32'(req_ready), 32'b010); adv();
        req_valid = 3'b000; rd_addr1 = 5'd0; rf_q1 = 32'h11;
        settle(); chk("z_q1", fwd_q1, 32'h0BADF00D); chk("z_q2", fwd_q2, 32'h55); adv();

        // Same address back to back commits in order
        req_valid = 3'b011; a[0] = 5'd4; a[1] = 5'd4; d[0] = 32'h1; d[1] = 32'h2; rd_addr1 = 5'd4;
        settle(); adv();
        settle(); chk("seq_wd1", rf_wdata, 32'h1); chk("seq_fwd1", fwd_q1, 32'h1); adv();
        req_valid = 3'b000;
        settle(); chk("seq_wd2", rf_wdata, 32'h2); chk("seq_fwd2", fwd_q1, 32'h2); adv();

        // Reset while a write is in flight
        req_valid = 3'b001; a[0] = 5'd7; d[0] = 32'h77777777;
        settle(); adv();
        req_valid = 3'b000; reset = 1'b1; rd_addr1 = 5'd7; rf_q1 = 32'h70;
        settle(); chk("mid_we", 32'(rf_we), 1); chk("mid_fwd", fwd_q1, 32'h77777777); adv();
        reset = 1'b0; req_valid = 3'b111;
        settle(); chk("mid_we0", 32'(rf_we), 0); chk("mid_fwd0", fwd_q1, 32'h70);
        chk("mid_ptr0", 32'(req_ready), 32'b001); adv();
        settle(); adv();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
